mem_access_unit: RTL

Load/store initiator for the single-port word RAM. Accepts byte, halfword and word load/store requests from the CPU datapath and drives the RAM's read_ram/write_ram strobe interface. Performs lane extraction with sign/zero extension on loads and read-modify-write for sub-word stores, because the RAM only writes whole words. Sits between the execute stage and the RAM; one transaction is in flight at a time.

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and the request legality check for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    LD    = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5
  } state_e;

  // Returns 1 for a misaligned access, the reserved size, or a word index
  // beyond the end of the attached RAM.
  function automatic logic access_error(input logic [31:0] addr,
                                        input size_e       size,
                                        input int unsigned ram_words);
    logic err;
    err = 1'b0;
    case (size)
      SZ_HALF: err = addr[0];
      SZ_WORD: err = (addr[1:0] != 2'b00);
      SZ_RSVD: err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= ram_words) err = 1'b1;
    return err;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte/half lane extraction with sign or zero
//               extension for loads, and lane insertion for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to a full word for loads.
  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    rdata = word;
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h000000, byte_sel}
                                   : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = is_unsigned ? {16'h0000, half_sel}
                                   : {{16{half_sel[15]}}, half_sel};
      default: rdata = word;
    endcase
  end

  // Replace the addressed lane of the old word with the right-aligned store data.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store initiator for a word RAM with
//               read/write strobes; sub-word stores use read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        read_ram,
  output logic        write_ram,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_out
);

  state_e      state, state_next;
  logic [31:0] addr_q;
  size_e       size_q;
  logic        unsigned_q;
  logic        write_q;
  logic [31:0] merge_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign accept  = req_valid && (state == IDLE);
  assign req_err = access_error(req_addr, size_e'(req_size), RAM_WORDS);

  mem_lane_align u_align (
    .word        (ram_out),
    .wdata       (merge_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (ld_data),
    .merged      (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs; strobes never depend on inputs.
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    read_ram       = 1'b0;
    write_ram      = 1'b0;
    resp_valid     = 1'b0;
    ram_addr       = 32'h0;
    ram_write_data = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                        state_next = RESP;
          else if (!req_write)                state_next = RD;
          else if (size_e'(req_size) == SZ_WORD) state_next = WR;
          else                                state_next = RD;
        end
      end
      RD: begin
        read_ram   = 1'b1;
        ram_addr   = {2'b00, addr_q[31:2]};
        state_next = write_q ? MERGE : LD;
      end
      MERGE: state_next = WR;
      LD:    state_next = RESP;
      WR: begin
        write_ram      = 1'b1;
        ram_addr       = {2'b00, addr_q[31:2]};
        ram_write_data = merge_q;
        state_next     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches, merge buffer and response registers; the response
  // registers only change on the edge entering RESP so they hold in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= 32'h0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      write_q      <= 1'b0;
      merge_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= req_addr;
            size_q     <= size_e'(req_size);
            unsigned_q <= req_unsigned;
            write_q    <= req_write;
            merge_q    <= req_wdata;
            if (req_err) begin
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
            end
          end
        end
        MERGE: merge_q <= merged;
        LD: begin
          resp_rdata_q <= ld_data;
          resp_err_q   <= 1'b0;
        end
        WR: begin
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

`default_nettype wire
